// File: rtl/aether_engine_stream_loader.sv
// Stream loader: collects upstream words into a burst FIFO, then issues one
// memory WRITE task per burst and streams the buffered words to the memory
// stage. Long jobs are split into BurstLen-sized tasks at consecutive addresses.
module aether_engine_stream_loader #(
  parameter int BurstLen = 16  // power of 2, 2..256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_address_i,
  input  logic [15:0] word_count_i,
  input  logic [15:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [1:0]  mem_command_o,
  output logic [31:0] mem_start_address_o,
  output logic [31:0] mem_end_address_o,
  output logic [15:0] mem_data_write_o,
  input  logic        mem_data_write_ready_i,
  input  logic        mem_task_finished_i,
  input  logic        mem_running_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        underrun_o,
  input  logic        assert_on_i
);

  localparam int PtrW = $clog2(BurstLen);
  localparam int CntW = PtrW + 1;
  localparam logic [15:0]     BurstLen16 = 16'(BurstLen);
  localparam logic [CntW-1:0] FullCount  = CntW'(BurstLen);
  localparam logic [CntW-1:0] OneCount   = CntW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CMD,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t state_reg;

  // Burst buffer
  logic [15:0]     fifo_mem [BurstLen];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] fifo_count_reg;

  // Job progress
  logic [31:0] cur_addr_reg;
  logic [15:0] remaining_reg;

  // Registered outputs
  logic        mem_cmd_reg;
  logic [31:0] mem_start_reg;
  logic [31:0] mem_end_reg;
  logic        done_reg;
  logic        underrun_reg;

  // Derived control
  logic [15:0] chunk;
  logic [15:0] fifo_count_ext;
  logic [15:0] remaining_next;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        underrun_evt;

  // Words in the current task: never more than one burst, never more than what is left.
  assign chunk          = (remaining_reg > BurstLen16) ? BurstLen16 : remaining_reg;
  assign fifo_count_ext = {{(16 - CntW){1'b0}}, fifo_count_reg};
  assign remaining_next = remaining_reg - chunk;
  assign fifo_empty     = (fifo_count_reg == '0);

  assign s_ready_o    = (state_reg == S_FILL) && (fifo_count_ext < chunk);
  assign push         = s_valid_i && s_ready_o;
  assign pop          = (state_reg == S_STREAM) && mem_data_write_ready_i && !fifo_empty;
  // A write request the loader cannot serve is an underrun; it never pops.
  assign underrun_evt = mem_data_write_ready_i && ((state_reg != S_STREAM) || fifo_empty);

  // Head is read asynchronously so the memory stage sees the word with no added
  // latency; an empty FIFO presents zero rather than stale storage.
  assign mem_data_write_o    = fifo_empty ? 16'd0 : fifo_mem[rd_ptr_reg];
  assign mem_command_o       = {1'b0, mem_cmd_reg};
  assign mem_start_address_o = mem_start_reg;
  assign mem_end_address_o   = mem_end_reg;
  assign busy_o              = (state_reg != S_IDLE);
  assign done_o              = done_reg;
  assign underrun_o          = underrun_reg;

  // FIFO storage write (storage itself needs no reset; occupancy is tracked separately)
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= s_data_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Job sequencing FSM with its registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      mem_cmd_reg   <= 1'b0;
      mem_start_reg <= '0;
      mem_end_reg   <= '0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      mem_cmd_reg <= 1'b0;
      done_reg    <= 1'b0;
      if (underrun_evt) begin
        underrun_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            cur_addr_reg  <= base_address_i;
            remaining_reg <= word_count_i;
            state_reg     <= (word_count_i == 16'd0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          // Command is registered here so it is high exactly while in CMD.
          if (fifo_count_ext == chunk) begin
            state_reg     <= S_CMD;
            mem_cmd_reg   <= 1'b1;
            mem_start_reg <= cur_addr_reg;
            mem_end_reg   <= cur_addr_reg + {16'd0, chunk} - 32'd1;
          end
        end
        S_CMD: begin
          state_reg <= S_STREAM;
        end
        S_STREAM: begin
          if (fifo_empty || (pop && (fifo_count_reg == OneCount))) begin
            state_reg <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (mem_task_finished_i && !mem_running_i) begin
            cur_addr_reg  <= cur_addr_reg + {16'd0, chunk};
            remaining_reg <= remaining_next;
            state_reg     <= (remaining_next == 16'd0) ? S_DONE : S_FILL;
          end
        end
        S_DONE: begin
          // done_o is registered off DONE, so it pulses on the cycle after it.
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Runtime-gated protocol checks (ignored by synthesis)
  always @(posedge clk_i) begin
    if (!rst_i && assert_on_i) begin
      assert (!underrun_evt)
        else $error("stream loader underrun: write ready with no word available");
      assert (!(push && (fifo_count_reg == FullCount)))
        else $error("stream loader FIFO push while full");
    end
  end

endmodule

// File: tb/tb_aether_engine_stream_loader.sv
// Bench for the stream loader: directed jobs, a memory-stage model that
// answers commands, and a scoreboard monitor checking commands, words and done.
module tb_aether_engine_stream_loader;

  localparam int BurstLen = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_address_i = '0;
  logic [15:0] word_count_i = '0;
  logic [15:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [1:0]  mem_command_o;
  logic [31:0] mem_start_address_o;
  logic [31:0] mem_end_address_o;
  logic [15:0] mem_data_write_o;
  logic        mem_data_write_ready_i;
  logic        mem_task_finished_i = 1'b1;
  logic        mem_running_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        underrun_o;
  logic        assert_on_i = 1'b1;

  logic mm_ready = 1'b0;
  logic force_ready = 1'b0;
  assign mem_data_write_ready_i = mm_ready | force_ready;

  always #5 clk_i = ~clk_i;

  aether_engine_stream_loader #(.BurstLen(BurstLen)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .start_i                (start_i),
    .base_address_i         (base_address_i),
    .word_count_i           (word_count_i),
    .s_data_i               (s_data_i),
    .s_valid_i              (s_valid_i),
    .s_ready_o              (s_ready_o),
    .mem_command_o          (mem_command_o),
    .mem_start_address_o    (mem_start_address_o),
    .mem_end_address_o      (mem_end_address_o),
    .mem_data_write_o       (mem_data_write_o),
    .mem_data_write_ready_i (mem_data_write_ready_i),
    .mem_task_finished_i    (mem_task_finished_i),
    .mem_running_i          (mem_running_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .underrun_o             (underrun_o),
    .assert_on_i            (assert_on_i)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [63:0] exp_cmd[$];   // {start, end}
  logic [15:0] exp_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic push_cmd(input logic [31:0] s, input logic [31:0] e);
    exp_cmd.push_back({s, e});
  endtask

  // Memory-stage model: answers each command by requesting its words
  int  mm_words_left = 0;
  int  mm_sent = 0;
  int  mm_stall_left = 0;
  bit  mm_stalled = 1'b0;
  bit  stall_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mm_ready            = 1'b0;
        mem_running_i       = 1'b0;
        mem_task_finished_i = 1'b1;
        mm_words_left       = 0;
        mm_stall_left       = 0;
      end else if (mem_command_o != 2'd0) begin
        logic [31:0] span;
        span                = mem_end_address_o - mem_start_address_o;
        mm_words_left       = (span >= 32'(BurstLen)) ? BurstLen : int'(span) + 1;
        mm_ready            = 1'b0;
        mem_running_i       = 1'b1;
        mem_task_finished_i = 1'b0;
        mm_sent             = 0;
        mm_stalled          = 1'b0;
        mm_stall_left       = 0;
      end else if (mm_words_left > 0) begin
        if (stall_en && mm_sent == 5 && !mm_stalled) begin
          mm_stall_left = 3;
          mm_stalled    = 1'b1;
        end
        if (mm_stall_left > 0) begin
          mm_ready = 1'b0;
          mm_stall_left--;
        end else begin
          mm_ready = 1'b1;
          mm_words_left--;
          mm_sent++;
        end
      end else if (mem_running_i) begin
        mm_ready            = 1'b0;
        mem_running_i       = 1'b0;
        mem_task_finished_i = 1'b1;
      end else begin
        mm_ready = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compares every command, every consumed word, counts done
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        if (mem_command_o != 2'd0) begin
          $display("cmd   code=%0d start=%h end=%h", mem_command_o, mem_start_address_o, mem_end_address_o);
          check("cmd_code", 64'(mem_command_o), 64'd1);
          if (exp_cmd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got start=%h end=%h, expected no command",
                     mem_start_address_o, mem_end_address_o);
          end else begin
            logic [63:0] want;
            want = exp_cmd.pop_front();
            check("cmd_start", 64'(mem_start_address_o), 64'(want[63:32]));
            check("cmd_end", 64'(mem_end_address_o), 64'(want[31:0]));
          end
        end
        if (mem_data_write_ready_i && !force_ready) begin
          $display("write data=%h", mem_data_write_o);
          if (exp_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got data=%h, expected no write", mem_data_write_o);
          end else begin
            check("wr_data", 64'(mem_data_write_o), 64'(exp_data.pop_front()));
          end
        end
        if (done_o) begin
          done_cnt++;
          $display("done  count=%0d", done_cnt);
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input logic [15:0] count, input logic [15:0] tag);
    for (int i = 0; i < int'(count); i++) begin
      exp_data.push_back(tag + 16'(i));
    end
    @(negedge clk_i);
    start_i        = 1'b1;
    base_address_i = base;
    word_count_i   = count;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic feed(input logic [15:0] count, input logic [15:0] tag,
                      input bit rand_valid, input bit spurious);
    int idx;
    int iter;
    idx  = 0;
    iter = 0;
    while (idx < int'(count) && iter < 4000) begin
      s_data_i  = tag + 16'(idx);
      s_valid_i = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (spurious) begin
        start_i        = (iter == 2);
        base_address_i = 32'hDEAD_0000;
        word_count_i   = 16'd3;
      end
      if (s_valid_i && s_ready_o) idx++;
      iter++;
      @(negedge clk_i);
      #1;
    end
    s_valid_i = 1'b0;
    start_i   = 1'b0;
    if (idx < int'(count)) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d words accepted, expected %0d", idx, count);
    end
  endtask

  task automatic finish_job(input int d0);
    int budget;
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(negedge clk_i);
      #2;
      budget++;
    end
    repeat (3) @(negedge clk_i);
    #2;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("cmd_left", 64'(exp_cmd.size()), 64'd0);
    check("data_left", 64'(exp_data.size()), 64'd0);
    check("underrun_clear", 64'(underrun_o), 64'd0);
    check("idle_after_job", 64'(busy_o), 64'd0);
  endtask

  task automatic run_job(input logic [31:0] base, input logic [15:0] count, input logic [15:0] tag,
                         input bit rand_valid, input bit spurious);
    int d0;
    d0 = done_cnt;
    start_job(base, count, tag);
    feed(count, tag, rand_valid, spurious);
    finish_job(d0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_cmd"}, 64'(mem_command_o), 64'd0);
    check({pfx, "_s_ready"}, 64'(s_ready_o), 64'd0);
    check({pfx, "_busy"}, 64'(busy_o), 64'd0);
    check({pfx, "_done"}, 64'(done_o), 64'd0);
    check({pfx, "_underrun"}, 64'(underrun_o), 64'd0);
    check({pfx, "_start_addr"}, 64'(mem_start_address_o), 64'd0);
    check({pfx, "_end_addr"}, 64'(mem_end_address_o), 64'd0);
    check({pfx, "_wr_data"}, 64'(mem_data_write_o), 64'd0);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int d0;
    int budget;

    repeat (2) @(negedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Single task: one burst
    push_cmd(32'h0000_0100, 32'h0000_010F);
    run_job(32'h0000_0100, 16'd16, 16'h1000, 1'b0, 1'b0);

    // Multi-chunk: 16 + 16 + 8
    push_cmd(32'h0000_0100, 32'h0000_010F);
    push_cmd(32'h0000_0110, 32'h0000_011F);
    push_cmd(32'h0000_0120, 32'h0000_0127);
    run_job(32'h0000_0100, 16'd40, 16'h2000, 1'b0, 1'b0);

    // Backpressure: sparse s_valid_i, 3-cycle write stall mid-stream
    stall_en = 1'b1;
    push_cmd(32'h0000_0500, 32'h0000_050F);
    push_cmd(32'h0000_0510, 32'h0000_0517);
    run_job(32'h0000_0500, 16'd24, 16'h3000, 1'b1, 1'b0);
    stall_en = 1'b0;

    // Zero-length job: done two cycles after start, no command
    d0 = done_cnt;
    @(negedge clk_i);
    start_i        = 1'b1;
    base_address_i = 32'h0000_0600;
    word_count_i   = 16'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("zero_done_c1", 64'(done_o), 64'd0);
    check("zero_busy_c1", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    #1;
    check("zero_done_c2", 64'(done_o), 64'd1);
    @(negedge clk_i);
    #2;
    check("zero_done_c3", 64'(done_o), 64'd0);
    check("zero_done_count", 64'(done_cnt - d0), 64'd1);

    // Address wrap at the top of the space
    push_cmd(32'hFFFF_FFF8, 32'h0000_0007);
    run_job(32'hFFFF_FFF8, 16'd16, 16'h4000, 1'b0, 1'b0);

    // start_i while busy must be ignored
    push_cmd(32'h0000_0200, 32'h0000_0207);
    run_job(32'h0000_0200, 16'd8, 16'h5000, 1'b0, 1'b1);

    // Underrun: write ready during FILL latches the sticky flag
    assert_on_i = 1'b0;
    @(negedge clk_i);
    start_i        = 1'b1;
    base_address_i = 32'h0000_0300;
    word_count_i   = 16'd4;
    @(negedge clk_i);
    start_i     = 1'b0;
    force_ready = 1'b1;
    @(negedge clk_i);
    force_ready = 1'b0;
    #1;
    check("underrun_set", 64'(underrun_o), 64'd1);
    check("underrun_still_filling", 64'(s_ready_o), 64'd1);
    repeat (3) @(negedge clk_i);
    #1;
    check("underrun_sticky", 64'(underrun_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("underrun_cleared", 64'(underrun_o), 64'd0);
    @(negedge clk_i);
    rst_i       = 1'b0;
    assert_on_i = 1'b1;

    // Reset in STREAM abandons the job; a fresh job then runs correctly
    d0 = done_cnt;
    push_cmd(32'h0000_0400, 32'h0000_040F);
    start_job(32'h0000_0400, 16'd16, 16'h6000);
    feed(16'd16, 16'h6000, 1'b0, 1'b0);
    budget = 0;
    while (mm_sent < 6 && budget < 500) begin
      @(negedge clk_i);
      budget++;
    end
    if (mm_sent < 6) begin
      checks++;
      errors++;
      $display("FAIL stream_wait_timeout: got %0d words, expected at least 6", mm_sent);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_all_zero("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_cmd.delete();
    exp_data.delete();
    repeat (3) @(negedge clk_i);
    #2;
    check("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);

    push_cmd(32'h0000_0700, 32'h0000_070F);
    push_cmd(32'h0000_0710, 32'h0000_0713);
    run_job(32'h0000_0700, 16'd20, 16'h7000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aether_engine_stream_loader.md
AETHER_ENGINE_STREAM_LOADER -- requirements
Module: aether_engine_stream_loader

Interface
REQ-001 SHALL have parameter BurstLen, default 16, max words per memory write task; power of 2, 2..256.
REQ-002 SHALL have parameter assert checks enabled at runtime via assert_on_i, not by parameter.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_i (input, 1, rising-edge clock), then rst_i (input, 1, synchronous active-high reset).
REQ-004 start_i  input  1  pulse; begins a load job when idle.
REQ-005 base_address_i  input  32  first memory word address of the job, sampled on start_i.
REQ-006 word_count_i  input  16  number of words in the job, sampled on start_i.
REQ-007 s_data_i  input  16  upstream stream word.
REQ-008 s_valid_i  input  1  s_data_i is valid.
REQ-009 s_ready_o  output  1  loader accepts s_data_i this cycle.
REQ-010 mem_command_o  output  2  0 = IDLE, 1 = WRITE; value 2 (READ) is never driven.
REQ-011 mem_start_address_o / mem_end_address_o  output  32 each  inclusive address range of the current task.
REQ-012 mem_data_write_o  output  16  word presented to the memory stage.
REQ-013 mem_data_write_ready_i  input  1  memory stage consumes mem_data_write_o this cycle.
REQ-014 mem_task_finished_i  input  1  memory stage task complete.
REQ-015 mem_running_i  input  1  memory stage has a command in flight.
REQ-016 busy_o  output  1; done_o  output  1 (one-cycle pulse); underrun_o  output  1 (sticky error).
REQ-017 assert_on_i  input  1  enables simulation assertions.

Function
REQ-018 The FSM SHALL have states IDLE, FILL, CMD, STREAM, WAIT_DONE, DONE.
REQ-019 Internal storage SHALL be a BurstLen-deep, 16-bit FIFO, plus a 32-bit cur_addr register and a 16-bit remaining register.
REQ-020 IDLE: on start_i, latch cur_addr = base_address_i and remaining = word_count_i; go to DONE if word_count_i == 0, else to FILL.
REQ-021 chunk SHALL equal min(BurstLen, remaining), computed from registered values only.
REQ-022 FILL: s_ready_o = 1 while FIFO count < chunk; a word is pushed on s_valid_i && s_ready_o.
REQ-023 FILL SHALL move to CMD in the cycle after FIFO count reaches chunk.
REQ-024 CMD: for exactly one cycle, drive mem_command_o = 1, mem_start_address_o = cur_addr, and mem_end_address_o = cur_addr + chunk - 1 (32-bit wrap); then go to STREAM.
REQ-025 Outside CMD, mem_command_o SHALL be 0; the address outputs SHALL hold their last values.
REQ-026 STREAM: mem_data_write_o SHALL be the FIFO head, combinational with zero added latency.
REQ-027 STREAM: each cycle mem_data_write_ready_i is high, exactly one word SHALL be popped.
REQ-028 STREAM SHALL move to WAIT_DONE when the FIFO empties.
REQ-029 WAIT_DONE: when mem_task_finished_i == 1 and mem_running_i == 0, update cur_addr += chunk and remaining -= chunk; go to DONE if the result is 0, else to FILL.
REQ-030 mem_task_finished_i SHALL be ignored in every state except WAIT_DONE; it may be high after memory-stage reset.
REQ-031 DONE: assert done_o for one cycle, then go to IDLE.
REQ-032 busy_o = 1 in every state except IDLE.
REQ-033 start_i SHALL be ignored while busy_o = 1.
REQ-034 Underrun: mem_data_write_ready_i high while the FIFO is empty, or while not in STREAM, sets underrun_o, and nothing is popped.
REQ-035 underrun_o SHALL clear only on rst_i.
REQ-036 When assert_on_i = 1, an underrun SHALL raise $error.
REQ-037 When assert_on_i = 1, a FIFO push when full SHALL raise $error.
REQ-038 s_ready_o = 0 in every state except FILL.

Reset
REQ-039 On rst_i, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-040 On rst_i, cur_addr, remaining, mem_start_address_o, mem_end_address_o and mem_data_write_o SHALL be 0.
REQ-041 On rst_i, mem_command_o, s_ready_o, busy_o, done_o and underrun_o SHALL be 0.
REQ-042 Reset mid-job SHALL abandon the job with no done_o pulse, and mem_command_o SHALL be 0 from the next cycle.

Verification
REQ-043 Single task: BurstLen = 16, base 0x100, count 16, 16 words streamed → exactly one mem_command_o = 1 pulse with start 0x100 and end 0x10F, 16 pops, then done_o.
REQ-044 Multi-chunk: count 40 → three tasks with ranges 0x100-0x10F, 0x110-0x11F, 0x120-0x127, then done_o once.
REQ-045 Backpressure: s_valid_i randomly low, mem_data_write_ready_i stalled 3 cycles mid-STREAM → every word is written in order with no loss and underrun_o stays 0.
REQ-046 Edges: count 0 → done_o 2 cycles after start_i with no mem command; base 0xFFFFFFF8, count 16 → end wraps to 0x00000007; start_i while busy → ignored.
REQ-047 Faults: mem_data_write_ready_i high in FILL → underrun_o latched 1; rst_i asserted in STREAM → all outputs 0 next cycle, and a new job then runs correctly.
